// File: rtl/cv_video_timing_pkg.sv
// ----------------------------------------------------------------------------
// cv_timing_pkg
// Shared constants and helpers for the raster timing generator.
//   - CNT_W / MAX_TOTAL : width of the h/v position counters and their limit
//   - DEF_*             : 640x480@60 default raster geometry
//   - axis_total / axis_sync_start / axis_sync_end : derive the line/frame
//     length and the [start, end) sync window from the four region sizes
// ----------------------------------------------------------------------------
package cv_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Regions are laid out as active, front porch, sync, back porch.
    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int axis_sync_start(int active, int fp);
        return active + fp;
    endfunction

    // Exclusive upper bound of the sync window.
    function automatic int axis_sync_end(int active, int fp, int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/cv_video_timing_if.sv
// ----------------------------------------------------------------------------
// cv_video_timing_if
// Raster timing bundle between the timing generator (master) and the
// HDMI encoder / line-buffer fill logic (slave).
//   h_en, h_sync, h_active, h_count : horizontal enable, sync, active, position
//   v_sync, v_active, v_count       : vertical sync, active, position
//   line_req, line_num              : one-line-ahead prefetch request
//   frame_cnt, frame_start          : present only with CV_VIDEO_TIMING_FRAME_CNT_EN
// ----------------------------------------------------------------------------
interface cv_video_timing_if;

    logic                           h_en;
    logic                           h_sync;
    logic                           h_active;
    logic [cv_timing_pkg::CNT_W-1:0] h_count;
    logic                           v_sync;
    logic                           v_active;
    logic [cv_timing_pkg::CNT_W-1:0] v_count;
    logic                           line_req;
    logic [cv_timing_pkg::CNT_W-1:0] line_num;
`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
    logic [7:0]                     frame_cnt;
    logic                           frame_start;
`endif

    modport master (
        output h_en, h_sync, h_active, h_count,
        output v_sync, v_active, v_count,
        output line_req, line_num
`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
        , output frame_cnt, frame_start
`endif
    );

    modport slave (
        input h_en, h_sync, h_active, h_count,
        input v_sync, v_active, v_count,
        input line_req, line_num
`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
        , input frame_cnt, frame_start
`endif
    );

endinterface

// File: rtl/cv_video_timing_axis.sv
// ----------------------------------------------------------------------------
// cv_timing_axis
// One raster axis: position counter plus registered active/sync decode.
// Used once for the horizontal axis and once for the vertical axis.
//   clk, reset  : clock, synchronous active-high reset
//   i_advance   : step the position by one (wraps TOTAL-1 -> 0)
//   o_count     : current position, 0 = first active pixel/line
//   o_active    : 1 while o_count < ACTIVE
//   o_sync      : SYNC_POL while SYNC_START <= o_count < SYNC_END
//   o_wrap      : position is TOTAL-1, so the next advance wraps to 0
// ----------------------------------------------------------------------------
module cv_timing_axis
    import cv_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    output logic [CNT_W-1:0] o_count,
    output logic             o_active,
    output logic             o_sync,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_count;
    logic             r_active;
    logic             r_sync;
    logic [CNT_W-1:0] w_next;
    logic             w_wrap;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here the default comes first) so no latch is inferred.
    always_comb begin
        w_next = r_count + 1'b1;
        if (w_wrap) begin
            w_next = '0;
        end
    end

    assign w_wrap = (r_count == CNT_W'(TOTAL - 1));

    // Active and sync are decoded from the value the counter is about to
    // take, so they change on the same edge as the count itself.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= CNT_W'(TOTAL - 1);
            r_active <= 1'b0;
            r_sync   <= ~SYNC_POL;
        end else if (i_advance) begin
            r_count  <= w_next;
            r_active <= (int'(w_next) < ACTIVE);
            r_sync   <= ((int'(w_next) >= SYNC_START) && (int'(w_next) < SYNC_END))
                        ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign o_count  = r_count;
    assign o_active = r_active;
    assign o_sync   = r_sync;
    assign o_wrap   = w_wrap;

endmodule

// File: rtl/cv_video_timing.sv
// ----------------------------------------------------------------------------
// cv_video_timing
// Raster timing generator for the HDMI output path.
//   clk, reset : clock, synchronous active-high reset
//   vid        : cv_video_timing_if.master
//                h_en / h_sync / h_active / h_count
//                v_sync / v_active / v_count
//                line_req / line_num (prefetch one line ahead of display)
//                frame_cnt / frame_start when CV_VIDEO_TIMING_FRAME_CNT_EN
//                is defined
// Optional feature macro: CV_VIDEO_TIMING_FRAME_CNT_EN
// ----------------------------------------------------------------------------
module cv_video_timing
    import cv_timing_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    cv_video_timing_if.master   vid
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
        $error("cv_video_timing: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
        $error("cv_video_timing: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1) begin : g_div_err
        $error("cv_video_timing: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_h_en;
    logic             r_line_req;
    logic [CNT_W-1:0] r_line_num;

    logic             w_tick;
    logic             w_v_advance;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_line_evt;
    logic [CNT_W-1:0] w_next_line;

    // Pixel divider: w_tick is the clock on which every counter moves and
    // h_en is raised alongside the new counter values.
    assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_h_en    <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_h_en    <= w_tick;
        end
    end

    assign w_v_advance = w_tick & w_h_wrap;

    cv_timing_axis #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (axis_sync_start(H_ACTIVE, H_FP)),
        .SYNC_END   (axis_sync_end(H_ACTIVE, H_FP, H_SYNC)),
        .SYNC_POL   (H_SYNC_POL)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_tick),
        .o_count   (w_h_count),
        .o_active  (w_h_active),
        .o_sync    (w_h_sync),
        .o_wrap    (w_h_wrap)
    );

    cv_timing_axis #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (axis_sync_start(V_ACTIVE, V_FP)),
        .SYNC_END   (axis_sync_end(V_ACTIVE, V_FP, V_SYNC)),
        .SYNC_POL   (V_SYNC_POL)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_v_advance),
        .o_count   (w_v_count),
        .o_active  (w_v_active),
        .o_sync    (w_v_sync),
        .o_wrap    (w_v_wrap)
    );

    // Prefetch: when the last active pixel of a line is left behind, ask
    // the fill logic for the line that will be displayed next. Lines that
    // fall in the vertical blanking interval are never requested.
    assign w_line_evt  = w_tick && (w_h_count == CNT_W'(H_ACTIVE - 1));
    assign w_next_line = w_v_wrap ? '0 : w_v_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line_req <= 1'b0;
            r_line_num <= '0;
        end else if (w_line_evt && (int'(w_next_line) < V_ACTIVE)) begin
            r_line_req <= 1'b1;
            r_line_num <= w_next_line;
        end else begin
            r_line_req <= 1'b0;
        end
    end

    assign vid.h_en     = r_h_en;
    assign vid.h_sync   = w_h_sync;
    assign vid.h_active = w_h_active;
    assign vid.h_count  = w_h_count;
    assign vid.v_sync   = w_v_sync;
    assign vid.v_active = w_v_active;
    assign vid.v_count  = w_v_count;
    assign vid.line_req = r_line_req;
    assign vid.line_num = r_line_num;

`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;
    logic       r_frame_start;

    // A frame starts on the advance that lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_v_advance & w_v_wrap;
            if (w_v_advance & w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign vid.frame_cnt   = r_frame_cnt;
    assign vid.frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_cv_video_timing.sv
// ----------------------------------------------------------------------------
// tb_cv_video_timing
// Three generator instances share one clock:
//   u_def : 640x480 defaults, CLK_DIV=1
//   u_div : 640x480 defaults, CLK_DIV=3
//   u_sm  : tiny 10x9 raster, H_SYNC_POL=1, so whole frames fit in a short run
// Expected outputs come from a position model: the n-th pixel tick after
// reset sits at linear raster index n-1, from which h/v position and every
// decode follow by division and range tests.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cv_video_timing;

    localparam int S_HA = 6, S_HFP = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 5, S_VFP = 1, S_VS = 2, S_VB = 1;

    typedef struct {
        int div;
        int ha, hfp, hs, hb;
        int va, vfp, vs, vb;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        logic h_en, h_sync, h_active, v_sync, v_active, line_req, frame_start;
        int   h, v, line_num, frame_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_def = 1'b1;
    logic rst_div = 1'b1;
    logic rst_sm  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    cfg_t cfg_def, cfg_div, cfg_sm;

    cv_video_timing_if if_def ();
    cv_video_timing_if if_div ();
    cv_video_timing_if if_sm  ();

    cv_video_timing #(.CLK_DIV(1)) u_def (.clk(clk), .reset(rst_def), .vid(if_def.master));
    cv_video_timing #(.CLK_DIV(3)) u_div (.clk(clk), .reset(rst_div), .vid(if_div.master));
    cv_video_timing #(
        .CLK_DIV(1),
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) u_sm (.clk(clk), .reset(rst_sm), .vid(if_sm.master));

    always #5 clk = ~clk;

    // c = clocks since reset was released (0 = still in / just left reset).
    function automatic exp_t model(cfg_t g, int c, int last_num);
        exp_t e;
        int ht, vt, n, lin, nl;
        ht = g.ha + g.hfp + g.hs + g.hb;
        vt = g.va + g.vfp + g.vs + g.vb;
        e.h_en = 1'b0; e.h_sync = ~g.hpol; e.h_active = 1'b0; e.h = ht - 1;
        e.v_sync = ~g.vpol; e.v_active = 1'b0; e.v = vt - 1;
        e.line_req = 1'b0; e.line_num = last_num;
        e.frame_start = 1'b0; e.frame_cnt = 0;
        if (c > 0) begin
            e.h_en = ((c % g.div) == 0);
            n = c / g.div;
            if (n > 0) begin
                lin = n - 1;
                e.h = lin % ht;
                e.v = (lin / ht) % vt;
                e.h_active = (e.h < g.ha);
                e.v_active = (e.v < g.va);
                e.h_sync = (e.h >= g.ha + g.hfp && e.h < g.ha + g.hfp + g.hs) ? g.hpol : ~g.hpol;
                e.v_sync = (e.v >= g.va + g.vfp && e.v < g.va + g.vfp + g.vs) ? g.vpol : ~g.vpol;
                nl = (e.v == vt - 1) ? 0 : e.v + 1;
                e.line_req = e.h_en && (e.h == g.ha) && (nl < g.va);
                if (e.line_req) e.line_num = nl;
                e.frame_start = e.h_en && ((lin % (ht * vt)) == 0);
                e.frame_cnt = ((lin / (ht * vt)) + 1) % 256;
            end
        end
        return e;
    endfunction

    function automatic logic [36:0] pack_obs(logic he, logic hs, logic ha, logic [9:0] hc,
                                             logic vs, logic va, logic [9:0] vc,
                                             logic lr, logic [9:0] ln);
        return {he, hs, ha, hc, vs, va, vc, lr, ln};
    endfunction

    function automatic logic [36:0] pack_exp(exp_t e);
        return pack_obs(e.h_en, e.h_sync, e.h_active, 10'(e.h), e.v_sync, e.v_active,
                        10'(e.v), e.line_req, 10'(e.line_num));
    endfunction

    // Layout of the printed vectors: {h_en,h_sync,h_active,h_count,v_sync,v_active,v_count,line_req,line_num}

    task automatic test_reset();
        exp_t e;
        logic [36:0] obs;
        int c, last;
        rst_def = 1'b0;
        repeat ($urandom_range(20, 300)) @(posedge clk);
        #1 rst_def = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = model(cfg_def, 0, 0);
            obs = pack_obs(if_def.h_en, if_def.h_sync, if_def.h_active, if_def.h_count,
                           if_def.v_sync, if_def.v_active, if_def.v_count, if_def.line_req, if_def.line_num);
            n_checks++;
            if (obs !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got=%h want=%h", i, obs, pack_exp(e));
            end
        end
        rst_def = 1'b0; c = 0; last = 0;
        @(posedge clk); #1; c++;
        n_checks++;
        if ({if_def.h_en, if_def.h_count, if_def.v_count, if_def.h_active, if_def.v_active}
            !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL first_advance got h_en=%b h=%0d v=%0d ha=%b va=%b want 1 0 0 1 1",
                     if_def.h_en, if_def.h_count, if_def.v_count, if_def.h_active, if_def.v_active);
        end
    endtask

    task automatic test_h_line();
        exp_t e;
        logic [36:0] obs;
        int c, last, hs_min, hs_max, ha_fall;
        rst_def = 1'b1; @(posedge clk); #1 rst_def = 1'b0;
        c = 0; last = 0; hs_min = 9999; hs_max = -1; ha_fall = -1;
        for (int i = 0; i < 800 + int'($urandom_range(0, 200)); i++) begin
            @(posedge clk); #1; c++;
            e = model(cfg_def, c, last); last = e.line_num;
            obs = pack_obs(if_def.h_en, if_def.h_sync, if_def.h_active, if_def.h_count,
                           if_def.v_sync, if_def.v_active, if_def.v_count, if_def.line_req, if_def.line_num);
            n_checks++;
            if (obs !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL h_line c=%0d got=%h want=%h", c, obs, pack_exp(e));
            end
            if (c <= 800) begin
                if (if_def.h_sync === 1'b0) begin
                    if (int'(if_def.h_count) < hs_min) hs_min = int'(if_def.h_count);
                    if (int'(if_def.h_count) > hs_max) hs_max = int'(if_def.h_count);
                end
                if (ha_fall < 0 && if_def.h_active === 1'b0) ha_fall = int'(if_def.h_count);
            end
        end
        n_checks++;
        if (hs_min != 656 || hs_max != 751) begin
            n_fail++;
            $display("FAIL h_sync_window got %0d..%0d want 656..751", hs_min, hs_max);
        end
        n_checks++;
        if (ha_fall != 640) begin
            n_fail++;
            $display("FAIL h_active_fall got %0d want 640", ha_fall);
        end
    endtask

    task automatic test_clk_div();
        exp_t e;
        logic [36:0] obs;
        int c, last, n_en, t0, t1;
        rst_div = 1'b1; @(posedge clk); #1 rst_div = 1'b0;
        c = 0; last = 0; n_en = 0; t0 = -1; t1 = -1;
        for (int i = 0; i < 4800 + int'($urandom_range(3, 300)); i++) begin
            @(posedge clk); #1; c++;
            e = model(cfg_div, c, last); last = e.line_num;
            obs = pack_obs(if_div.h_en, if_div.h_sync, if_div.h_active, if_div.h_count,
                           if_div.v_sync, if_div.v_active, if_div.v_count, if_div.line_req, if_div.line_num);
            n_checks++;
            if (obs !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL clk_div c=%0d got=%h want=%h", c, obs, pack_exp(e));
            end
            if (c <= 2400 && if_div.h_en === 1'b1) n_en++;
            if (if_div.h_en === 1'b1 && if_div.h_count == 10'd0) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
        end
        n_checks++;
        if (n_en != 800) begin
            n_fail++;
            $display("FAIL h_en_rate got %0d pulses in 2400 clks want 800", n_en);
        end
        n_checks++;
        if (t1 - t0 != 2400) begin
            n_fail++;
            $display("FAIL line_period got %0d clks want 2400", t1 - t0);
        end
    endtask

    task automatic test_vertical();
        exp_t e;
        logic [36:0] obs;
        int c, last, vs_min, vs_max, va_fall, n_wrap, prev_v, prev_h;
        rst_sm = 1'b1; @(posedge clk); #1 rst_sm = 1'b0;
        c = 0; last = 0; vs_min = 9999; vs_max = -1; va_fall = -1; n_wrap = 0;
        prev_v = -1; prev_h = -1;
        for (int i = 0; i < 180 + int'($urandom_range(1, 60)); i++) begin
            @(posedge clk); #1; c++;
            e = model(cfg_sm, c, last); last = e.line_num;
            obs = pack_obs(if_sm.h_en, if_sm.h_sync, if_sm.h_active, if_sm.h_count,
                           if_sm.v_sync, if_sm.v_active, if_sm.v_count, if_sm.line_req, if_sm.line_num);
            n_checks++;
            if (obs !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL vertical c=%0d got=%h want=%h", c, obs, pack_exp(e));
            end
            if (if_sm.v_sync === 1'b0) begin
                if (int'(if_sm.v_count) < vs_min) vs_min = int'(if_sm.v_count);
                if (int'(if_sm.v_count) > vs_max) vs_max = int'(if_sm.v_count);
            end
            if (va_fall < 0 && c > 1 && if_sm.v_active === 1'b0) va_fall = int'(if_sm.v_count);
            if (prev_v == 8 && if_sm.v_count == 10'd0) begin
                n_wrap++;
                n_checks++;
                if (prev_h != 9 || if_sm.h_count !== 10'd0 || if_sm.v_active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL v_wrap got h %0d->%0d va=%b want h 9->0 va=1",
                             prev_h, if_sm.h_count, if_sm.v_active);
                end
            end
            prev_v = int'(if_sm.v_count);
            prev_h = int'(if_sm.h_count);
        end
        n_checks++;
        if (vs_min != 6 || vs_max != 7 || va_fall != 5 || n_wrap != 2) begin
            n_fail++;
            $display("FAIL v_regions got sync %0d..%0d fall %0d wraps %0d want 6..7 fall 5 wraps 2",
                     vs_min, vs_max, va_fall, n_wrap);
        end
    endtask

    task automatic test_line_req();
        exp_t e;
        logic [36:0] obs;
        int c, last, nl;
        int want_q[$];
        int got_q[$];
        for (int v = 0; v < 9; v++) begin
            nl = (v == 8) ? 0 : v + 1;
            if (nl < S_VA) want_q.push_back(nl);
        end
        rst_sm = 1'b1; @(posedge clk); #1 rst_sm = 1'b0;
        c = 0; last = 0;
        for (int i = 0; i < 90; i++) begin
            @(posedge clk); #1; c++;
            e = model(cfg_sm, c, last); last = e.line_num;
            obs = pack_obs(if_sm.h_en, if_sm.h_sync, if_sm.h_active, if_sm.h_count,
                           if_sm.v_sync, if_sm.v_active, if_sm.v_count, if_sm.line_req, if_sm.line_num);
            n_checks++;
            if (obs !== pack_exp(e)) begin
                n_fail++;
                $display("FAIL line_req_seq c=%0d got=%h want=%h", c, obs, pack_exp(e));
            end
            if (if_sm.line_req === 1'b1) got_q.push_back(int'(if_sm.line_num));
        end
        n_checks++;
        if (got_q.size() != S_VA) begin
            n_fail++;
            $display("FAIL line_req_count got %0d want %0d", got_q.size(), S_VA);
        end
        for (int k = 0; k < want_q.size() && k < got_q.size(); k++) begin
            n_checks++;
            if (got_q[k] != want_q[k]) begin
                n_fail++;
                $display("FAIL line_num[%0d] got %0d want %0d", k, got_q[k], want_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [36:0] obs;
        int c, last, run;
        for (int r = 0; r < 6; r++) begin
            // First pass stops inside both sync pulses (h=7, v=6).
            run = (r == 0) ? 68 : int'($urandom_range(1, 200));
            rst_sm = 1'b1; @(posedge clk); #1 rst_sm = 1'b0;
            c = 0; last = 0;
            for (int i = 0; i < run + 30; i++) begin
                if (i == run) begin
                    rst_sm = 1'b1;
                    @(posedge clk); #1 rst_sm = 1'b0;
                    c = 0; last = 0;
                end else begin
                    @(posedge clk); #1; c++;
                end
                e = model(cfg_sm, c, last); last = e.line_num;
                obs = pack_obs(if_sm.h_en, if_sm.h_sync, if_sm.h_active, if_sm.h_count,
                               if_sm.v_sync, if_sm.v_active, if_sm.v_count, if_sm.line_req, if_sm.line_num);
                n_checks++;
                if (obs !== pack_exp(e)) begin
                    n_fail++;
                    $display("FAIL reset_mid r=%0d i=%0d got=%h want=%h", r, i, obs, pack_exp(e));
                end
            end
        end
    endtask

`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        exp_t e;
        int c, n_start;
        rst_sm = 1'b1; @(posedge clk); #1;
        n_checks++;
        if (if_sm.frame_cnt !== 8'd0 || if_sm.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_reset got cnt=%0d start=%b want 0 0", if_sm.frame_cnt, if_sm.frame_start);
        end
        rst_sm = 1'b0; c = 0; n_start = 0;
        for (int i = 0; i < 257 * 90; i++) begin
            @(posedge clk); #1; c++;
            e = model(cfg_sm, c, 0);
            if (if_sm.frame_start === 1'b1) n_start++;
            n_checks++;
            if (if_sm.frame_cnt !== 8'(e.frame_cnt) || if_sm.frame_start !== e.frame_start) begin
                n_fail++;
                $display("FAIL frame_cnt c=%0d got cnt=%0d start=%b want %0d %b",
                         c, if_sm.frame_cnt, if_sm.frame_start, e.frame_cnt, e.frame_start);
            end
        end
        n_checks++;
        if (n_start != 257 || if_sm.frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL frame_total got starts=%0d cnt=%0d want 257 1", n_start, if_sm.frame_cnt);
        end
    endtask
`endif

    initial begin
        cfg_def = '{div: 1, ha: 640, hfp: 16, hs: 96, hb: 48,
                    va: 480, vfp: 10, vs: 2, vb: 33, hpol: 1'b0, vpol: 1'b0};
        cfg_div = cfg_def;
        cfg_div.div = 3;
        cfg_sm  = '{div: 1, ha: S_HA, hfp: S_HFP, hs: S_HS, hb: S_HB,
                    va: S_VA, vfp: S_VFP, vs: S_VS, vb: S_VB, hpol: 1'b1, vpol: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_h_line();
        test_clk_div();
        test_vertical();
        test_line_req();
        test_reset_mid();
`ifdef CV_VIDEO_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cv_video_timing.md
Name: cv_video_timing

Overview:
Raster timing generator that drives the HDMI output path: pixel clock-enable, h/v sync, h/v active, and horizontal pixel position.
- Sits directly upstream of the line-buffer-to-HDMI encoder and feeds it h_en, h_sync, h_active, h_count, v_sync, v_active.
- Also issues a per-line prefetch request to the line-buffer fill logic, one line ahead of display.

Parameters:
CLK_DIV, 1, clk cycles per pixel; h_en pulses once every CLK_DIV clocks (1 = h_en constant high after reset)
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
H_SYNC_POL, 0, asserted level of h_sync
V_SYNC_POL, 0, asserted level of v_sync

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
h_en  output  1  pixel clock-enable, one clk wide
h_sync  output  1  horizontal sync, level per H_SYNC_POL
h_active  output  1  1 while h_count < H_ACTIVE
h_count  output  10  horizontal position, 0..H_TOTAL-1; 0 = first active pixel
v_sync  output  1  vertical sync, level per V_SYNC_POL
v_active  output  1  1 while v_count < V_ACTIVE
v_count  output  10  vertical position, 0..V_TOTAL-1; 0 = first active line
line_req  output  1  one-clk pulse requesting line-buffer fill
line_num  output  10  line index for line_req; held until the next request

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤1024; elaboration error otherwise.
- Region order on each axis: active, front porch, sync, back porch.
- h_sync is asserted for H_ACTIVE+H_FP ≤ h_count < H_ACTIVE+H_FP+H_SYNC; v_sync uses the same rule on the vertical axis.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. h_en=1 in the clk where div_cnt==CLK_DIV-1.
- Counters advance only on h_en clocks. h_count wraps H_TOTAL-1→0. v_count increments, wrapping V_TOTAL-1→0, only on the h_count wrap.
- All outputs are registered and updated on the same edge as the counters, so decode is always consistent with h_count/v_count (zero-latency decode relative to counters).
- Reset state, synchronous:
  - div_cnt=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1.
  - h_en=0, h_active=0, v_active=0.
  - h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL.
  - line_req=0, line_num=0.
- First advance after reset lands on (0,0) with h_active=v_active=1.
- Reset mid-frame: the next clock returns to the reset state; no partial sync pulse is extended.
- line_req:
  - Evaluated on the h_en edge where h_count becomes H_ACTIVE (end of active pixels).
  - next = (v_count==V_TOTAL-1) ? 0 : v_count+1.
  - If next < V_ACTIVE: line_req=1 for that clk and line_num=next. Otherwise no pulse.
- Simultaneous h wrap and v wrap: both counters go to 0 in the same clk, and v_active/v_sync update in that same clk.

Optional Feature:
CV_VIDEO_TIMING_FRAME_CNT_EN
- Defined: adds output frame_cnt [7:0], reset 0. It increments, wrapping 255→0, on the clk where (h_count,v_count) advances to (0,0). Also adds output frame_start, a one-clk pulse on that same clk.
- Undefined: neither port exists; no frame counter logic.

Decomposition:
- Package cv_timing_pkg holds the 640x480@60 default constants (H_*/V_* values) and a localparam function computing totals and sync-region bounds.
- One sub-module, cv_timing_axis: generic counter plus active/sync decode with an advance input and a wrap output. It is instantiated twice, horizontal and vertical.

Test Plan:
- CLK_DIV=1 defaults, release reset: 1st clk h_en=1, h_count=0, v_count=0, h_active=v_active=1. h_sync=0 exactly for h_count 656..751; h_active falls at h_count 640.
- CLK_DIV=3: h_en high 1 clk in 3; h_count steps once per h_en; one line spans 2400 clks.
- Vertical: v_sync=0 for v_count 490..491 only; v_active falls at v_count 480; v_count wraps 524→0 together with h_count 799→0.
- line_req: at v_count=0, h_count→640, pulse with line_num=1. At v_count=479 no pulse. At v_count=524, pulse with line_num=0. Exactly 480 pulses per frame.
- Assert reset at h_count=300, v_count=200 for 1 clk: next clk shows reset state; the following h_en gives (0,0).
- With CV_VIDEO_TIMING_FRAME_CNT_EN: run 257 frames; frame_cnt goes 0..255→0→1, and frame_start pulses 257 times.
